// File: rtl/button_conditioner.sv
// Push-button conditioner: polarity normalisation, 2-flop synchroniser, debounce FSM and
// registered press/release pulses per channel. Define BTN_REPEAT_EN to add auto-repeat pulses.
module button_conditioner #(
    parameter int              NBTN            = 4,
    parameter int              DEBOUNCE_CYCLES = 120000,
    parameter logic [NBTN-1:0] ACTIVE_LOW_MASK = 4'b1000,
    parameter int              REPEAT_DELAY    = 6000000,
    parameter int              REPEAT_RATE     = 1200000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NBTN-1:0]     btn_raw,
    output logic [NBTN-1:0]     btn_level,
    output logic [NBTN-1:0]     btn_press,
    output logic [NBTN-1:0]     btn_release,
    output logic [NBTN-1:0]     btn_repeat,
    output logic [2*NBTN-1:0]   dbg_state
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

`ifdef BTN_REPEAT_EN
    localparam int            RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW       = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST  = RW'(REPEAT_RATE - 1);
`endif

    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_CHK_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_CHK_UP = 2'd3
    } state_t;

    for (genvar g = 0; g < NBTN; g++) begin : g_ch
        logic          sync1_q, sync2_q;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                state_q   <= ST_UP;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= btn_raw[g] ^ ACTIVE_LOW_MASK[g];
                sync2_q   <= sync1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Counter saturates; every state change below clears it explicitly.
        always_comb begin
            state_d   = state_q;
            cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                ST_UP: begin
                    cnt_d = '0;
                    if (sync2_q) state_d = ST_CHK_DN;
                end
                ST_CHK_DN: begin
                    if (!sync2_q) begin
                        state_d = ST_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end
                end
                ST_DOWN: begin
                    cnt_d = '0;
                    if (!sync2_q) state_d = ST_CHK_UP;
                end
                ST_CHK_UP: begin
                    if (sync2_q) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_UP;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign btn_level[g]          = level_q;
        assign btn_press[g]          = press_q;
        assign btn_release[g]        = release_q;
        assign dbg_state[2*g +: 2]   = state_q;

`ifdef BTN_REPEAT_EN
        logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
        logic          rpt_first_q, rpt_first_d;
        logic          rpt_q, rpt_d;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                rpt_cnt_q   <= '0;
                rpt_first_q <= 1'b0;
                rpt_q       <= 1'b0;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_first_q <= rpt_first_d;
                rpt_q       <= rpt_d;
            end
        end

        // Advances only while steadily held in DOWN; CHK_UP (or leaving DOWN) freezes it.
        always_comb begin
            rpt_cnt_d   = rpt_cnt_q;
            rpt_first_d = rpt_first_q;
            rpt_d       = 1'b0;
            if (state_q == ST_DOWN && sync2_q) begin
                if (!rpt_first_q && rpt_cnt_q == RD_LAST) begin
                    rpt_d       = 1'b1;
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
                end else if (rpt_first_q && rpt_cnt_q == RR_LAST) begin
                    rpt_d     = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end else if (state_q == ST_UP || state_q == ST_CHK_DN) begin
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end
        end

        assign btn_repeat[g] = rpt_q;
`else
        assign btn_repeat[g] = 1'b0;
`endif
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Synchronises, debounces and edge-detects the board push-buttons (BTN1, BTN2, BTN3, BTN_N) before they reach the top-level display/accumulator logic. The top-level capture register and display select are clocked from CLK and qualified by this block's outputs. No logic is clocked directly from a raw button. Every output is active-high "pressed" regardless of the pin's electrical polarity.

## Interface
Parameters:
- `NBTN`, 4, number of buttons handled; one independent channel per bit.
- `DEBOUNCE_CYCLES`, 120000, consecutive stable samples required to accept a change (10 ms at 12 MHz); must be ≥ 1.
- `ACTIVE_LOW_MASK`, 4'b1000, bit set means that raw input is pressed-when-0 (BTN_N on bit 3).
- `REPEAT_DELAY`, 6000000, cycles held before the first auto-repeat pulse (used only with `BTN_REPEAT_EN`); ≥ 1.
- `REPEAT_RATE`, 1200000, cycles between subsequent auto-repeat pulses (used only with `BTN_REPEAT_EN`); ≥ 1.

Ports:
- `CLK`, input, 1, system clock; all state is on its rising edge.
- `RST_N`, input, 1, asynchronous active-low reset; deassertion is expected synchronous to CLK.
- `btn_raw`, input, NBTN, unsynchronised pin levels.
- `btn_level`, output, NBTN, debounced pressed state (1 = pressed).
- `btn_press`, output, NBTN, one-cycle pulse on accepted press.
- `btn_release`, output, NBTN, one-cycle pulse on accepted release.
- `btn_repeat`, output, NBTN, one-cycle auto-repeat pulse while held; constant 0 without `BTN_REPEAT_EN`.

## Operation
- **Polarity normalisation.** Each channel XORs `btn_raw` with `ACTIVE_LOW_MASK`, so 1 = pressed, before any other logic.
- **Synchroniser.** Each channel has a 2-flop synchroniser.
  - Both flops reset to 0 (released) after normalisation.
  - For active-low bits, the normalised reset value corresponds to a pin level of 1.
- **Per-channel FSM.** States and transitions, with sample = synchroniser output:
  - UP: sample=1 → CHK_DN, count cleared.
  - CHK_DN:
    - sample=0 → UP, count cleared, no pulse.
    - Otherwise count increments.
    - When count reaches DEBOUNCE_CYCLES−1 with sample=1 → DOWN; `btn_level`=1; `btn_press`=1 for one cycle.
  - DOWN: sample=0 → CHK_UP, count cleared.
  - CHK_UP:
    - sample=1 → DOWN, no pulse.
    - Otherwise count increments.
    - When count reaches DEBOUNCE_CYCLES−1 with sample=0 → UP; `btn_level`=0; `btn_release`=1 for one cycle.
- **Counter.** Each channel's counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide, saturates (never wraps), and is cleared on every state change.
- **Channel independence.** Channels are fully independent; simultaneous presses on several channels produce same-cycle pulses on each.
- **Pulse exclusivity.** `btn_press`, `btn_release` and `btn_repeat` are never asserted together on one channel.
- **Reset.**
  - Applies immediately and asynchronously.
  - All FSMs go to UP and all counters to 0.
  - All outputs go to 0: `btn_level`, `btn_press`, `btn_release`, `btn_repeat`.
  - A button held through reset is reported as a fresh press after reset deasserts, following full synchroniser + debounce latency.

## Timing
- **Press latency.** Edge E is the first rising edge at which the normalised pin is 1 and stays 1.
  - Synchroniser output is 1 after E+1.
  - CHK_DN is entered at E+2.
  - `btn_level` rises and `btn_press` is high in the cycle after edge E+2+DEBOUNCE_CYCLES.
- **Release latency.** Symmetric to press latency.
- **Pulse width.** Exactly one CLK cycle; all outputs are registered.
- **Glitch rejection.** A glitch shorter than DEBOUNCE_CYCLES samples, as seen at the synchroniser output, produces no output change.
- **Minimum gap.** Accepted transitions on one channel are at least DEBOUNCE_CYCLES+1 cycles apart.

## Configuration
- **`BTN_REPEAT_EN` defined.**
  - Each channel adds a repeat counter, active only in DOWN and CHK_UP.
  - The first `btn_repeat` pulse comes REPEAT_DELAY cycles after the `btn_press` pulse.
  - Further pulses come every REPEAT_RATE cycles while in DOWN.
  - Entering CHK_UP freezes the repeat counter; returning to DOWN resumes it.
  - Entering UP clears it.
- **`BTN_REPEAT_EN` undefined.**
  - No repeat logic is synthesised.
  - `btn_repeat` is tied to 0.
  - All other behaviour is identical.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Clean press on `btn_raw[0]` at edge E, then held → `btn_level[0]`=1 and a single `btn_press[0]` pulse after edge E+6; no other bits change.
- Bounce on bit 1: 1 for 3 cycles, 0 for 1, then 1 steady → no pulse during the bounce; `btn_press[1]` 4+2 edges after the last 0→1 transition.
- BTN_N (bit 3): pin driven 1 from reset, then 0 → `btn_level[3]` stays 0 through reset; press pulse 6 edges after the pin goes 0. Pin back to 1 → `btn_release[3]` 6 edges later.
- All four buttons pressed on the same edge → all four `btn_press` bits pulse in the same cycle.
- `RST_N` asserted mid-CHK_DN and while DOWN → all outputs 0 immediately. Button still held after release of reset → new `btn_press` after 6 edges.
- With `BTN_REPEAT_EN`, hold 30 cycles → `btn_repeat[0]` at 10, 13, 16, 19 … cycles after `btn_press`. Without the macro, `btn_repeat` stays 0.
